// File: rtl/state_seq.sv
// state_seq: four-step state sequencer with a per-state minimum dwell time.
// A sequence walks curr_state 00 -> 01 -> 10 -> 11 and returns to idle with a
// one-cycle done pulse. Each state is held at least dwell_len cycles; an advance
// needs step=1 while the dwell counter is zero. abort ends a sequence early
// without done.
// Build option: define SKIP_STATE2_EN to drop state 10 (sequence 00 -> 01 -> 11).
module state_seq #(
    parameter int unsigned DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               step,
    input  logic               abort,
    input  logic [DWELL_W-1:0] dwell_len,
    output logic [0:1]         curr_state,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        StS0 = 2'b00,
        StS1 = 2'b01,
        StS2 = 2'b10,
        StS3 = 2'b11
    } state_e;

    state_e             state;
    logic [DWELL_W-1:0] dwell_cnt;
    logic               busy_r;
    logic               done_r;

    // Successor of an active state; StS3 is handled as completion by the caller.
    function automatic state_e next_state(input state_e s);
        state_e n;
        unique case (s)
            StS0:    n = StS1;
`ifdef SKIP_STATE2_EN
            StS1:    n = StS3;
`else
            StS1:    n = StS2;
`endif
            StS2:    n = StS3;
            default: n = StS0;
        endcase
        return n;
    endfunction

    // Sequencer: state, dwell counter and registered busy/done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= StS0;
            dwell_cnt <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (!busy_r) begin
                // abort also wins over start when idle
                if (start && !abort) begin
                    busy_r    <= 1'b1;
                    state     <= StS0;
                    dwell_cnt <= dwell_len;
                end
            end else if (abort) begin
                busy_r    <= 1'b0;
                state     <= StS0;
                dwell_cnt <= '0;
            end else if (step && (dwell_cnt == '0)) begin
                if (state == StS3) begin
                    busy_r    <= 1'b0;
                    state     <= StS0;
                    done_r    <= 1'b1;
                    dwell_cnt <= '0;
                end else begin
                    state     <= next_state(state);
                    dwell_cnt <= dwell_len;
                end
            end else if (dwell_cnt != '0) begin
                // step with a nonzero count is dropped, not queued
                dwell_cnt <= dwell_cnt - DWELL_W'(1);
            end
        end
    end

    assign curr_state = state;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule
